// File: rtl/pe_relay_pkg.sv
// pe_relay_pkg: shared definitions for the pe_relay block.
//   - Default channel widths and buffer depth used as parameter defaults.
//   - lvl_w(): width of an occupancy counter able to hold 0..depth.
package pe_relay_pkg;

  localparam int WEST_WIDTH_DEF  = 134;
  localparam int NORTH_WIDTH_DEF = 130;
  localparam int SOUTH_WIDTH_DEF = 164;
  localparam int EAST_WIDTH_DEF  = 130;
  localparam int DEPTH_DEF       = 4;

  // Occupancy runs 0..depth inclusive, hence depth+1 states.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pe_relay_fifo.sv
// pe_relay_fifo: one buffered relay channel (synchronous FIFO).
// Ports:
//   clk, reset       - clock; asynchronous active-low reset
//   ap_start         - enables the output side (pops and out_valid)
//   flush            - synchronous clear of level and pointers
//   in_data/in_valid/in_ready    - write side handshake
//   out_data/out_valid/out_ready - read side handshake
//   level            - current occupancy
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push, pop;

  // Ready depends only on stored occupancy and reset, never on out_ready.
  assign in_ready  = reset && (level_q != FULL_LVL);
  assign out_valid = ap_start && (level_q != '0);

  // Flush overrides any handshake in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // When empty, present the most recently popped word (zero after reset).
  assign out_data = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/pe_relay.sv
// pe_relay: four independent buffered channels (west, north, south, east).
// Each in_from_D stream is relayed in order to out_to_D through its own FIFO.
// Ports:
//   clk, reset (async, active-low), ap_start (output-side enable), flush
//   per D: in_from_D / _valid / _ready, out_to_D / _valid / _ready, D_level
module pe_relay
  import pe_relay_pkg::*;
#(
  parameter int WEST_WIDTH  = WEST_WIDTH_DEF,
  parameter int NORTH_WIDTH = NORTH_WIDTH_DEF,
  parameter int SOUTH_WIDTH = SOUTH_WIDTH_DEF,
  parameter int EAST_WIDTH  = EAST_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic                     flush,
  input  logic [WEST_WIDTH-1:0]    in_from_west,
  input  logic                     in_from_west_valid,
  output logic                     in_from_west_ready,
  output logic [WEST_WIDTH-1:0]    out_to_west,
  output logic                     out_to_west_valid,
  input  logic                     out_to_west_ready,
  output logic [lvl_w(DEPTH)-1:0]  west_level,
  input  logic [NORTH_WIDTH-1:0]   in_from_north,
  input  logic                     in_from_north_valid,
  output logic                     in_from_north_ready,
  output logic [NORTH_WIDTH-1:0]   out_to_north,
  output logic                     out_to_north_valid,
  input  logic                     out_to_north_ready,
  output logic [lvl_w(DEPTH)-1:0]  north_level,
  input  logic [SOUTH_WIDTH-1:0]   in_from_south,
  input  logic                     in_from_south_valid,
  output logic                     in_from_south_ready,
  output logic [SOUTH_WIDTH-1:0]   out_to_south,
  output logic                     out_to_south_valid,
  input  logic                     out_to_south_ready,
  output logic [lvl_w(DEPTH)-1:0]  south_level,
  input  logic [EAST_WIDTH-1:0]    in_from_east,
  input  logic                     in_from_east_valid,
  output logic                     in_from_east_ready,
  output logic [EAST_WIDTH-1:0]    out_to_east,
  output logic                     out_to_east_valid,
  input  logic                     out_to_east_ready,
  output logic [lvl_w(DEPTH)-1:0]  east_level
);

  pe_relay_fifo #(.WIDTH(WEST_WIDTH), .DEPTH(DEPTH)) u_west (
    .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
    .in_data(in_from_west), .in_valid(in_from_west_valid), .in_ready(in_from_west_ready),
    .out_data(out_to_west), .out_valid(out_to_west_valid), .out_ready(out_to_west_ready),
    .level(west_level)
  );

  pe_relay_fifo #(.WIDTH(NORTH_WIDTH), .DEPTH(DEPTH)) u_north (
    .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
    .in_data(in_from_north), .in_valid(in_from_north_valid), .in_ready(in_from_north_ready),
    .out_data(out_to_north), .out_valid(out_to_north_valid), .out_ready(out_to_north_ready),
    .level(north_level)
  );

  pe_relay_fifo #(.WIDTH(SOUTH_WIDTH), .DEPTH(DEPTH)) u_south (
    .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
    .in_data(in_from_south), .in_valid(in_from_south_valid), .in_ready(in_from_south_ready),
    .out_data(out_to_south), .out_valid(out_to_south_valid), .out_ready(out_to_south_ready),
    .level(south_level)
  );

  pe_relay_fifo #(.WIDTH(EAST_WIDTH), .DEPTH(DEPTH)) u_east (
    .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
    .in_data(in_from_east), .in_valid(in_from_east_valid), .in_ready(in_from_east_ready),
    .out_data(out_to_east), .out_valid(out_to_east_valid), .out_ready(out_to_east_ready),
    .level(east_level)
  );

endmodule

// File: tb/tb_pe_relay.sv
// tb_pe_relay: table-driven bench with a queue scoreboard per channel.
// Channel index: 0 west, 1 north, 2 south, 3 east.
module tb_pe_relay;
  import pe_relay_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int LW    = lvl_w(DEPTH_DEF);
  localparam int MW    = 164;

  typedef logic [MW-1:0] word_t;

  typedef struct packed {
    logic             ap;
    logic             fl;
    logic [3:0]       iv;
    logic [3:0]       ordy;
    logic [3:0][LW-1:0] lvl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ap_start = 1'b0;
  logic flush = 1'b0;
  word_t din [4];
  logic [3:0] iv = 4'b0;
  logic [3:0] ordy = 4'b0;

  logic [133:0] o_w;
  logic [129:0] o_n;
  logic [163:0] o_s;
  logic [129:0] o_e;
  logic ir_w, ir_n, ir_s, ir_e;
  logic ov_w, ov_n, ov_s, ov_e;
  logic [LW-1:0] lv_w, lv_n, lv_s, lv_e;

  int checks = 0;
  int failures = 0;

  word_t sb [4][$];
  word_t last [4];
  int unsigned seq [4];
  string nm [4] = '{"west", "north", "south", "east"};
  vec_t tbl [$];

  always #5 clk = ~clk;

  pe_relay dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
    .in_from_west(din[0][133:0]), .in_from_west_valid(iv[0]), .in_from_west_ready(ir_w),
    .out_to_west(o_w), .out_to_west_valid(ov_w), .out_to_west_ready(ordy[0]), .west_level(lv_w),
    .in_from_north(din[1][129:0]), .in_from_north_valid(iv[1]), .in_from_north_ready(ir_n),
    .out_to_north(o_n), .out_to_north_valid(ov_n), .out_to_north_ready(ordy[1]), .north_level(lv_n),
    .in_from_south(din[2][163:0]), .in_from_south_valid(iv[2]), .in_from_south_ready(ir_s),
    .out_to_south(o_s), .out_to_south_valid(ov_s), .out_to_south_ready(ordy[2]), .south_level(lv_s),
    .in_from_east(din[3][129:0]), .in_from_east_valid(iv[3]), .in_from_east_ready(ir_e),
    .out_to_east(o_e), .out_to_east_valid(ov_e), .out_to_east_ready(ordy[3]), .east_level(lv_e)
  );

  function automatic word_t dout(input int c);
    case (c)
      0: return MW'(o_w);
      1: return MW'(o_n);
      2: return o_s;
      default: return MW'(o_e);
    endcase
  endfunction

  function automatic logic dvld(input int c);
    case (c)
      0: return ov_w;
      1: return ov_n;
      2: return ov_s;
      default: return ov_e;
    endcase
  endfunction

  function automatic logic drdy(input int c);
    case (c)
      0: return ir_w;
      1: return ir_n;
      2: return ir_s;
      default: return ir_e;
    endcase
  endfunction

  function automatic logic [LW-1:0] dlvl(input int c);
    case (c)
      0: return lv_w;
      1: return lv_n;
      2: return lv_s;
      default: return lv_e;
    endcase
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ap, input logic fl, input logic [3:0] v,
                              input logic [3:0] r, input int lw, input int ln,
                              input int ls, input int le);
    vec_t x;
    x.ap = ap; x.fl = fl; x.iv = v; x.ordy = r;
    x.lvl[0] = LW'(lw); x.lvl[1] = LW'(ln); x.lvl[2] = LW'(ls); x.lvl[3] = LW'(le);
    return x;
  endfunction

  // Drive one cycle, check outputs before the edge against the scoreboard,
  // then advance the scoreboard with what the edge should have done.
  task automatic cyc(input logic ap, input logic fl, input logic [3:0] v, input logic [3:0] r);
    logic acc_push, acc_pop;
    word_t e_out;
    ap_start = ap; flush = fl; iv = v; ordy = r;
    for (int c = 0; c < 4; c++) din[c] = MW'(seq[c]);
    #1;
    for (int c = 0; c < 4; c++) begin
      e_out = (sb[c].size() > 0) ? sb[c][0] : last[c];
      chk({nm[c], "_ready"}, MW'(drdy(c)), MW'(sb[c].size() < DEPTH));
      chk({nm[c], "_valid"}, MW'(dvld(c)), MW'(ap && (sb[c].size() > 0)));
      chk({nm[c], "_out"},   dout(c), e_out);
      chk({nm[c], "_level"}, MW'(dlvl(c)), MW'(sb[c].size()));
    end
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      acc_push = v[c] && (sb[c].size() < DEPTH);
      acc_pop  = ap && r[c] && (sb[c].size() > 0);
      if (fl) begin
        sb[c].delete();
      end else begin
        if (acc_pop) last[c] = sb[c].pop_front();
        if (acc_push) sb[c].push_back(MW'(seq[c]));
      end
      if (v[c]) seq[c]++;
    end
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      din[c] = '0;
      last[c] = '0;
      seq[c] = 1;
    end

    // Row set: west single word, north/south fill with ap_start low,
    // south drain in order, east streaming push+pop.
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b1111, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b1111, 1, 2, 2, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b1111, 1, 3, 3, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b1111, 1, 4, 4, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b1111, 1, 4, 4, 0));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, 4, 3, 0));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, 4, 3, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0100, 1, 4, 2, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0100, 1, 4, 1, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0100, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0100, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1011, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1010, 0, 2, 0, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 0, 2, 0, 1));

    // Reset asserted from time zero.
    #2;
    for (int c = 0; c < 4; c++) begin
      chk({"rst_", nm[c], "_ready"}, MW'(drdy(c)), '0);
      chk({"rst_", nm[c], "_valid"}, MW'(dvld(c)), '0);
      chk({"rst_", nm[c], "_out"},   dout(c), '0);
      chk({"rst_", nm[c], "_level"}, MW'(dlvl(c)), '0);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].ap, tbl[i].fl, tbl[i].iv, tbl[i].ordy);
      for (int c = 0; c < 4; c++)
        chk($sformatf("tbl%0d_%s_level", i, nm[c]), MW'(dlvl(c)), MW'(tbl[i].lvl[c]));
    end

    // Flush with a concurrent north push at level 2: everything cleared, word dropped.
    cyc(0, 1, 4'b0010, 4'b0000);
    chk("flush_north_level", MW'(lv_n), '0);
    chk("flush_east_level", MW'(lv_e), '0);
    cyc(1, 0, 4'b0000, 4'b1111);

    // Three words into west, then an asynchronous reset between edges.
    cyc(0, 0, 4'b0001, 4'b0000);
    cyc(0, 0, 4'b0001, 4'b0000);
    cyc(0, 0, 4'b0001, 4'b0000);
    ap_start = 1'b1; iv = 4'b0; ordy = 4'b0;
    #1;
    chk("pre_rst_west_valid", MW'(ov_w), MW'(1));
    reset = 1'b0;
    #1;
    chk("async_west_out", MW'(o_w), '0);
    chk("async_west_valid", MW'(ov_w), '0);
    chk("async_west_level", MW'(lv_w), '0);
    chk("async_west_ready", MW'(ir_w), '0);
    for (int c = 0; c < 4; c++) begin
      sb[c].delete();
      last[c] = '0;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    cyc(1, 0, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0000, 4'b0001);
    cyc(1, 0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_relay.md
PE_RELAY -- requirements
Module: pe_relay

Interface
REQ-001 Parameter WEST_WIDTH, default 134, west channel data width in bits.
REQ-002 Parameter NORTH_WIDTH, default 130, north channel data width in bits.
REQ-003 Parameter SOUTH_WIDTH, default 164, south channel data width in bits.
REQ-004 Parameter EAST_WIDTH, default 130, east channel data width in bits.
REQ-005 Parameter DEPTH, default 4, per-channel buffer entries; SHALL be a power of two, at least 2.
REQ-006 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-008 Port ap_start, input, 1, output-side enable for all channels.
REQ-009 Port flush, input, 1, synchronous clear of all channel buffers.
REQ-010 For each D in {west, north, south, east}: port in_from_D, input, D_WIDTH, incoming data.
REQ-011 Per D: in_from_D_valid, input, 1, incoming word present.
REQ-012 Per D: in_from_D_ready, output, 1, buffer can accept a word.
REQ-013 Per D: out_to_D, output, D_WIDTH, head-of-buffer data.
REQ-014 Per D: out_to_D_valid, output, 1, out_to_D holds a word.
REQ-015 Per D: out_to_D_ready, input, 1, downstream consumes the word.
REQ-016 Per D: D_level, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-017 Each channel SHALL be an independent FIFO; in_from_D feeds out_to_D only, in order, with no cross-channel interaction.
REQ-018 Push SHALL occur when in_from_D_valid and in_from_D_ready are both 1 on a rising edge.
REQ-019 in_from_D_ready SHALL be 1 exactly when D_level < DEPTH and reset is deasserted; it SHALL NOT depend combinationally on out_to_D_ready.
REQ-020 out_to_D_valid SHALL be 1 exactly when D_level > 0 and ap_start is 1.
REQ-021 Pop SHALL occur when out_to_D_valid and out_to_D_ready are both 1 on a rising edge.
REQ-022 Latency: a word pushed at edge t SHALL appear on out_to_D with valid after edge t (visible in cycle t+1), given ap_start = 1.
REQ-023 Simultaneous push and pop on a non-empty, non-full buffer SHALL leave D_level unchanged and preserve order.
REQ-024 Full: push is blocked by ready = 0; a pop in that cycle frees one entry, and ready SHALL be 1 the following cycle.
REQ-025 Empty: out_to_D SHALL hold the last popped value (0 after reset) and valid SHALL be 0.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH without gaps.
REQ-027 ap_start = 0 SHALL block pops and force out_to_D_valid to 0; pushes SHALL continue until full.
REQ-028 flush = 1 SHALL zero every level and pointer at the next edge, overriding any same-cycle push or pop.
REQ-029 D_level SHALL equal pushes minus pops since the last reset or flush.

Reset
REQ-030 While reset = 0: all levels and pointers 0, all out_to_D 0, all out_to_D_valid 0, all in_from_D_ready 0.
REQ-031 Reset assertion SHALL take effect asynchronously mid-operation and discard buffered words; deassertion SHALL be synchronised to clk by the integrator.
REQ-032 In the first cycle after deassertion, all in_from_D_ready SHALL be 1.

Structure
REQ-033 A shared package SHALL hold the default widths, DEPTH, and the level-width function.
REQ-034 The block SHALL instantiate one sub-module, pe_relay_fifo (parameters WIDTH and DEPTH), four times.

Verification
REQ-035 Reset, then push 0x1 on west with ap_start=1 -> out_to_west=0x1, valid=1 in the next cycle; west_level=1.
REQ-036 DEPTH=4, ap_start=0, push 5 words on north -> ready drops after the 4th; north_level=4; 5th not accepted.
REQ-037 Full south, assert ap_start and out_to_south_ready -> words out in order 1,2,3,4; ready returns after first pop.
REQ-038 Continuous push+pop on east for 10 cycles -> east_level constant at 1; output sequence equals input sequence delayed 1 cycle.
REQ-039 Assert reset low with 3 words in west -> out_to_west=0, valid=0, level=0 immediately, with no clock edge needed.
REQ-040 flush with a concurrent push on north (level 2) -> north_level=0 next cycle; the pushed word is dropped.
